// File: rtl/psum_pkg.sv
// Shared psum types and the accumulate/saturate helper.
// Optional saturation is enabled by defining PSUM_ACCUM_SAT_EN.
package psum_pkg;

  localparam int DEF_PSUM_W = 48;
  localparam int DEF_MEM_W  = 64;

  typedef logic signed [DEF_PSUM_W-1:0] psum_t;

  localparam psum_t PSUM_MAX = {1'b0, {(DEF_PSUM_W-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(DEF_PSUM_W-1){1'b0}}};

  // Signed overflow: operands agree in sign but the wrapped sum does not.
  function automatic logic psum_ovf(psum_t a, psum_t b);
    psum_t s;
    s = a + b;
    return (a[DEF_PSUM_W-1] == b[DEF_PSUM_W-1]) && (s[DEF_PSUM_W-1] != a[DEF_PSUM_W-1]);
  endfunction

  function automatic psum_t psum_add(psum_t a, psum_t b);
    psum_t s;
    s = a + b;
`ifdef PSUM_ACCUM_SAT_EN
    if (psum_ovf(a, b)) s = a[DEF_PSUM_W-1] ? PSUM_MIN : PSUM_MAX;
`endif
    return s;
  endfunction

endpackage

// File: rtl/psum_fwd_sel.sv
// Old-value select for the accumulate stage: first-pass zero, then
// forwarding from the two younger writes, else the bank read data.
module psum_fwd_sel
  import psum_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ADDR_W = 32
) (
  input  logic              first,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic              s2_vld,
  input  logic [ADDR_W-1:0] s2_addr,
  input  logic [PSUM_W-1:0] s2_data,
  input  logic              s3_vld,
  input  logic [ADDR_W-1:0] s3_addr,
  input  logic [PSUM_W-1:0] s3_data,
  input  logic [PSUM_W-1:0] rd_data,
  output logic [PSUM_W-1:0] old
);

  always_comb begin
    old = rd_data;
    if (first)                              old = '0;
    else if (s2_vld && s2_addr == s1_addr)  old = s2_data;
    else if (s3_vld && s3_addr == s1_addr)  old = s3_data;
  end

endmodule

// File: rtl/psum_accum.sv
// Per-row psum read-modify-write accumulator in front of a read-first bank.
// Define PSUM_ACCUM_SAT_EN for saturating sums and a sticky sat_flag.
module psum_accum
  import psum_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int MEM_W  = DEF_MEM_W,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [PSUM_W-1:0]  in_psum,
  input  logic               clr_count,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [MEM_W-1:0]   mem_rd_data,
  output logic [MEM_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [MEM_W-1:0]   mem_wr_data,
  output logic               busy,
  output logic [31:0]        wr_count,
  output logic               sat_flag
);

  localparam int STAGES = 2;
  localparam int BE_W   = MEM_W/8;
  localparam logic [BE_W-1:0] WE_MASK = {BE_W{1'b1}} >> ((MEM_W-PSUM_W)/8);

  // vld_pipe[0]=S1, [1]=S2 (write on the bus), [2]=S3 (forwarding only)
  logic [STAGES:0]   vld_pipe;
  logic              s1_first;
  logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr;
  logic [PSUM_W-1:0] s1_psum, s2_data, s3_data;
  logic [PSUM_W-1:0] old, sum;
  psum_t             op_a, op_b;

  logic unused_rd_hi;
  assign unused_rd_hi = ^mem_rd_data[MEM_W-1:PSUM_W];

  assign mem_rd_addr = in_addr;

  psum_fwd_sel #(.PSUM_W(PSUM_W), .ADDR_W(ADDR_W)) u_fwd (
    .first   (s1_first),
    .s1_addr (s1_addr),
    .s2_vld  (vld_pipe[1]),
    .s2_addr (s2_addr),
    .s2_data (s2_data),
    .s3_vld  (vld_pipe[2]),
    .s3_addr (s3_addr),
    .s3_data (s3_data),
    .rd_data (mem_rd_data[PSUM_W-1:0]),
    .old     (old)
  );

  assign op_a = psum_t'(old);
  assign op_b = psum_t'(s1_psum);
  assign sum  = PSUM_W'(psum_add(op_a, op_b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s2_addr  <= '0;
      s2_data  <= '0;
      wr_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (vld_pipe[0]) begin
        s2_addr <= s1_addr;
        s2_data <= sum;
      end
      if (clr_count)        wr_count <= '0;
      else if (vld_pipe[1]) wr_count <= wr_count + 32'd1;
    end
  end

  // Datapath-only registers; their valids qualify them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_first <= in_first;
      s1_addr  <= in_addr;
      s1_psum  <= in_psum;
    end
    if (vld_pipe[1]) begin
      s3_addr <= s2_addr;
      s3_data <= s2_data;
    end
  end

`ifdef PSUM_ACCUM_SAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                                         sat_flag <= 1'b0;
    else if (vld_pipe[0] && psum_ovf(op_a, op_b))       sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

  assign mem_we      = vld_pipe[1] ? WE_MASK : '0;
  assign mem_wr_addr = s2_addr;
  assign mem_wr_data = MEM_W'(s2_data);
  assign busy        = in_valid | vld_pipe[0] | vld_pipe[1];

endmodule
